mips_cpu_bus_stall_ram: RTL and testbench

Avalon-style slave RAM for the bus-interface MIPS CPU, sitting directly downstream of the CPU's memory port in the bus testbench. It decodes the CPU's 32-bit byte address against a base window, applies a programmable number of waitrequest stall cycles per transaction, and performs byte-enabled word reads and writes. It also flags protocol violations and counts completed accesses, so benches can check CPU bus behaviour.

---
 rtl/mips_cpu_bus_stall_ram.sv | 105 ++++++++++
 tb/tb_mips_cpu_bus_stall_ram.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_bus_stall_ram.sv
// Avalon-style slave RAM for the bus MIPS CPU: base-window decode, programmable
// waitrequest stall, byte-enabled word access, sticky protocol error and access count.
module mips_cpu_bus_stall_ram #(
  parameter string       RAM_INIT_FILE   = "",
  parameter logic [31:0] BASE_ADDR       = 32'hBFC00000,
  parameter int          WORD_ADDR_WIDTH = 13,
  parameter int          WAIT_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        error,
  output logic [31:0] access_count,
  output logic        dbg_state
);

  localparam int          DEPTH     = 1 << WORD_ADDR_WIDTH;
  localparam logic [32:0] SPAN      = 33'd4 << WORD_ADDR_WIDTH;
  localparam logic [7:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] areg;
  logic [31:0] mem [DEPTH];

  logic [31:0]                offset;
  logic [WORD_ADDR_WIDTH-1:0] word;
  logic                       req;
  logic                       ok;
  logic                       complete;
  logic                       good;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  // Offset wraps modulo 2^32, so addresses below the base land out of range.
  assign offset    = address - BASE_ADDR;
  assign word      = offset[WORD_ADDR_WIDTH+1:2];
  assign req       = read | write;
  assign ok        = (address[1:0] == 2'b00) && ({1'b0, offset} < SPAN) && !(read && write);
  assign complete  = reset && req &&
                     ((state == IDLE && ZERO_WAIT) || (state == STALL && cnt == 8'd0));
  assign good      = complete && ok;
  assign readdata  = (good && read) ? mem[word] : 32'h0;
  assign dbg_state = state;

  always_comb begin
    waitrequest = 1'b0;
    if (reset) begin
      if (state == STALL) waitrequest = (cnt != 8'd0);
      else                waitrequest = req && !ZERO_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      areg         <= 32'h0;
      error        <= 1'b0;
      access_count <= 32'h0;
    end else begin
      if (complete && !ok) error <= 1'b1;
      if (good) access_count <= access_count + 32'd1;
      case (state)
        IDLE: begin
          if (req && !ZERO_WAIT) begin
            areg  <= address;
            cnt   <= CNT_INIT;
            state <= STALL;
          end
        end
        STALL: begin
          // A dropped request aborts silently; the error flag is left alone.
          if (!req) begin
            state <= IDLE;
          end else begin
            if (address != areg) error <= 1'b1;
            if (cnt == 8'd0) state <= IDLE;
            else             cnt   <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (good && write) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[word][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_stall_ram.sv
// Bench for mips_cpu_bus_stall_ram: directed table, randomized accesses against a
// word-level model, and hand sequences for stall, error and reset corner cases.
module tb_mips_cpu_bus_stall_ram;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        error;
  logic [31:0] access_count;
  logic        dbg_state;

  logic [31:0] address0 = '0;
  logic        read0 = 1'b0;
  logic        write0 = 1'b0;
  logic [3:0]  byteenable0 = '0;
  logic [31:0] writedata0 = '0;
  logic        waitrequest0;
  logic [31:0] readdata0;
  logic        error0;
  logic [31:0] access_count0;
  logic        dbg_state0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_stall_ram #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .error(error), .access_count(access_count), .dbg_state(dbg_state)
  );

  mips_cpu_bus_stall_ram #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .address(address0), .read(read0), .write(write0),
    .byteenable(byteenable0), .writedata(writedata0), .waitrequest(waitrequest0),
    .readdata(readdata0), .error(error0), .access_count(access_count0), .dbg_state(dbg_state0)
  );

  // Reference model: sparse word store plus expected error flag and count.
  logic [31:0] ref_mem [int unsigned];
  logic        m_err = 1'b0;
  logic [31:0] m_cnt = '0;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    int unsigned idx = (a - BASE) >> 2;
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic model_apply(input logic r, input logic w, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] d,
                             output logic [31:0] exp_rd);
    int unsigned idx = (a - BASE) >> 2;
    logic [31:0] word;
    exp_rd = 32'h0;
    if (a[1:0] != 2'b00 || (a - BASE) >= 32'h8000 || (r && w)) begin
      m_err = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
      if (r) begin
        exp_rd = mrd(a);
      end else begin
        word = mrd(a);
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = d[8*i +: 8];
        ref_mem[idx] = word;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    read = 1'b0;
    write = 1'b0;
    read0 = 1'b0;
    write0 = 1'b0;
    reset = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One full transaction on the stalling instance; returns stall count and read data.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        output int waits, output logic [31:0] rd);
    bit done = 0;
    waits = 0;
    rd = 32'h0;
    @(posedge clk);
    #1;
    read = r; write = w; address = a; byteenable = be; writedata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        rd = readdata;
        done = 1;
        break;
      end
      waits++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL access_timeout: got no completion in 20 cycles, expected 2 stalls");
    end
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          waits;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        r, w;
    logic [31:0] a;
    int          rw, sel;

    tbl[0] = '{1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 32'd1};
    tbl[1] = '{1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 32'd2};
    tbl[2] = '{1'b0, 1'b1, 32'hBFC00020, 4'hF, 32'h11223344, 32'h0,        1'b0, 32'd3};
    tbl[3] = '{1'b0, 1'b1, 32'hBFC00020, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0, 32'd4};
    tbl[4] = '{1'b1, 1'b0, 32'hBFC00020, 4'h0, 32'h0,        32'h11BB33DD, 1'b0, 32'd5};
    tbl[5] = '{1'b0, 1'b1, 32'hBFC00020, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0, 32'd6};
    tbl[6] = '{1'b1, 1'b0, 32'hBFC00020, 4'hF, 32'h0,        32'h11BB33DD, 1'b0, 32'd7};
    tbl[7] = '{1'b1, 1'b0, 32'hBFC07FFC, 4'hF, 32'h0,        32'h0,        1'b0, 32'd8};

    do_reset();
    @(negedge clk);
    check("reset_error", {31'b0, error}, 32'h0);
    check("reset_count", access_count, 32'h0);
    check("reset_wait", {31'b0, waitrequest}, 32'h0);
    check("reset_state", {31'b0, dbg_state}, 32'h0);

    // Zero-wait instance: one word per cycle, waitrequest never high.
    @(posedge clk); #1;
    write0 = 1'b1; address0 = 32'hBFC00000; byteenable0 = 4'hF; writedata0 = 32'hCAFEF00D;
    @(negedge clk); check("zw_wait_w0", {31'b0, waitrequest0}, 32'h0);
    @(posedge clk); #1;
    address0 = 32'hBFC00004; writedata0 = 32'h0BADC0DE;
    @(negedge clk); check("zw_wait_w1", {31'b0, waitrequest0}, 32'h0);
    @(posedge clk); #1;
    write0 = 1'b0; read0 = 1'b1; address0 = 32'hBFC00000;
    @(negedge clk);
    check("zw_wait_r0", {31'b0, waitrequest0}, 32'h0);
    check("zw_rd0", readdata0, 32'hCAFEF00D);
    @(posedge clk); #1;
    address0 = 32'hBFC00004;
    @(negedge clk);
    check("zw_wait_r1", {31'b0, waitrequest0}, 32'h0);
    check("zw_rd1", readdata0, 32'h0BADC0DE);
    @(posedge clk); #1;
    read0 = 1'b0;
    @(negedge clk);
    check("zw_count", access_count0, 32'd4);
    check("zw_state", {31'b0, dbg_state0}, 32'h0);
    check("zw_error", {31'b0, error0}, 32'h0);

    foreach (tbl[i]) begin
      access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d, waits, rd);
      model_apply(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d, exp_rd);
      check($sformatf("tbl%0d_waits", i), waits, 32'd2);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_error", i), {31'b0, error}, {31'b0, tbl[i].exp_err});
      check($sformatf("tbl%0d_count", i), access_count, tbl[i].exp_cnt);
    end

    for (int n = 0; n < 40; n++) begin
      rw = $urandom_range(0, 15);
      r = (rw == 0) || rw[0];
      w = (rw == 0) || !rw[0];
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE + 32'h8000 + 4 * $urandom_range(0, 15);
      else if (sel == 1) a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (sel == 2) a = BASE - 32'd4;
      else               a = BASE + 4 * $urandom_range(0, 15);
      access(r, w, a, 4'($urandom_range(0, 15)), $urandom, waits, rd);
      model_apply(r, w, a, byteenable, writedata, exp_rd);
      check("rnd_waits", waits, 32'd2);
      check("rnd_rdata", rd, exp_rd);
      check("rnd_error", {31'b0, error}, {31'b0, m_err});
      check("rnd_count", access_count, m_cnt);
    end

    // Out of range and misaligned: normal timing, zero data, error, no count.
    do_reset();
    access(1'b1, 1'b0, 32'hBFC08000, 4'hF, 32'h0, waits, rd);
    check("oor_waits", waits, 32'd2);
    check("oor_rdata", rd, 32'h0);
    check("oor_error", {31'b0, error}, 32'h1);
    check("oor_count", access_count, 32'h0);
    access(1'b1, 1'b0, 32'hBFC00002, 4'hF, 32'h0, waits, rd);
    check("mis_waits", waits, 32'd2);
    check("mis_rdata", rd, 32'h0);
    check("mis_count", access_count, 32'h0);

    do_reset();
    exp_rd = mrd(32'hBFC00040);
    access(1'b1, 1'b1, 32'hBFC00040, 4'hF, 32'h12345678, waits, rd);
    check("rw_rdata", rd, 32'h0);
    check("rw_error", {31'b0, error}, 32'h1);
    check("rw_count", access_count, 32'h0);
    access(1'b1, 1'b0, 32'hBFC00040, 4'hF, 32'h0, waits, rd);
    check("rw_nowrite", rd, exp_rd);
    check("rw_count2", access_count, 32'h1);

    // Address changed mid-stall: error, but completion uses the new address.
    do_reset();
    @(posedge clk); #1;
    read = 1'b1; address = 32'hBFC00010;
    @(posedge clk); #1;
    address = 32'hBFC00020;
    @(negedge clk); check("chg_wait", {31'b0, waitrequest}, 32'h1);
    @(negedge clk);
    check("chg_wait_done", {31'b0, waitrequest}, 32'h0);
    check("chg_rdata", readdata, mrd(32'hBFC00020));
    @(posedge clk); #1;
    read = 1'b0;
    check("chg_error", {31'b0, error}, 32'h1);
    check("chg_count", access_count, 32'h1);

    // Request dropped mid-stall aborts without count or error.
    do_reset();
    @(posedge clk); #1;
    read = 1'b1; address = 32'hBFC00010;
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_state", {31'b0, dbg_state}, 32'h0);
    check("drop_count", access_count, 32'h0);
    check("drop_error", {31'b0, error}, 32'h0);

    // Reset asserted mid-stall with read held, then a fresh full stall.
    access(1'b1, 1'b0, 32'hBFC00008, 4'hF, 32'h0, waits, rd);
    access(1'b1, 1'b0, 32'hBFC00009, 4'hF, 32'h0, waits, rd);
    @(posedge clk); #1;
    read = 1'b1; address = 32'hBFC00010;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_wait", {31'b0, waitrequest}, 32'h0);
    check("rst_state", {31'b0, dbg_state}, 32'h0);
    check("rst_error", {31'b0, error}, 32'h0);
    check("rst_count", access_count, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    waits = 0;
    rd = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        rd = readdata;
        break;
      end
      waits++;
    end
    @(posedge clk); #1;
    read = 1'b0;
    check("rst_waits", waits, 32'd2);
    check("rst_rdata", rd, mrd(32'hBFC00010));
    check("rst_count2", access_count, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
